// File: rtl/rtc_hms_timekeeper_if.sv
// Time-set request bundle for rtc_hms_timekeeper.
// Master issues set requests; slave acknowledges and flags rejects.
interface rtc_hms_timekeeper_if;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_h;
  logic       set_pm;
  logic [5:0] set_m;
  logic [5:0] set_s;
  logic       set_err;

  modport master (
    output set_valid, set_h, set_pm,
    output set_m, set_s,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_h, set_pm,
    input  set_m, set_s,
    output set_ready, set_err
  );
endinterface

// File: rtl/rtc_hms_timekeeper.sv
// hh:mm:ss timekeeper with 12h/24h display and checked time-set.
// Define RTC_ALARM_EN to add the hh:mm alarm comparator.
module rtc_hms_timekeeper #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DIV_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  rtc_hms_timekeeper_if.slave set,
`ifdef RTC_ALARM_EN
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  input  logic       alarm_arm,
  output logic       alarm_hit,
`endif
  output logic [4:0] hour_o,
  output logic       pm_o,
  output logic [5:0] min_o,
  output logic [5:0] sec_o,
  output logic       sec_pulse,
  output logic       day_pulse
);

  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div;
  logic [4:0]       h24;
  logic [5:0]       m;
  logic [5:0]       s;
  logic [4:0]       h_n;
  logic [5:0]       m_n;
  logic [5:0]       s_n;
  logic [4:0]       cap_h;
  logic             cap_pm;
  logic [5:0]       cap_m;
  logic [5:0]       cap_s;
  logic             cap_12h;
  logic [4:0]       hconv;
  logic             ok;
  logic             hs;
  logic             tick;
  logic             commit;
  logic             last_sec;

  assign tick     = run && (div == DIV_MAX);
  assign commit   = (state == COMMIT);
  assign hs       = set.set_valid && set.set_ready;
  assign last_sec = (s == 6'd59) && (m == 6'd59)
                 && (h24 == 5'd23);

  always_comb begin
    s_n = s + 6'd1;
    m_n = m;
    h_n = h24;
    if (s == 6'd59) begin
      s_n = 6'd0;
      m_n = m + 6'd1;
      if (m == 6'd59) begin
        m_n = 6'd0;
        h_n = (h24 == 5'd23) ? 5'd0 : h24 + 5'd1;
      end
    end
  end

  always_comb begin
    ok = (cap_m <= 6'd59) && (cap_s <= 6'd59);
    if (cap_12h)
      ok = ok && (cap_h >= 5'd1) && (cap_h <= 5'd12);
    else
      ok = ok && (cap_h <= 5'd23);
  end

  always_comb begin
    hconv = cap_h;
    if (cap_12h) begin
      if (cap_h == 5'd12)
        hconv = cap_pm ? 5'd12 : 5'd0;
      else if (cap_pm)
        hconv = cap_h + 5'd12;
    end
  end

  always_comb begin
    state_nxt     = state;
    set.set_ready = 1'b0;
    unique case (state)
      IDLE: begin
        set.set_ready = 1'b1;
        if (set.set_valid) state_nxt = CHECK;
      end
      CHECK:   state_nxt = ok ? COMMIT : IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      set.set_err <= 1'b0;
      cap_h       <= '0;
      cap_pm      <= 1'b0;
      cap_m       <= '0;
      cap_s       <= '0;
      cap_12h     <= 1'b0;
    end else begin
      state       <= state_nxt;
      set.set_err <= (state == CHECK) && !ok;
      if (hs) begin
        cap_h   <= set.set_h;
        cap_pm  <= set.set_pm;
        cap_m   <= set.set_m;
        cap_s   <= set.set_s;
        cap_12h <= mode_12h;
      end else if (state == CHECK) begin
        cap_h <= hconv;
      end
    end
  end

  // A commit overrides a coincident prescaler wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      h24       <= '0;
      m         <= '0;
      s         <= '0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      sec_pulse <= tick && !commit;
      day_pulse <= tick && !commit && last_sec;
      if (commit) begin
        div <= '0;
        h24 <= cap_h;
        m   <= cap_m;
        s   <= cap_s;
      end else if (run) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          h24 <= h_n;
          m   <= m_n;
          s   <= s_n;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      alarm_hit <= 1'b0;
    else
      alarm_hit <= tick && !commit && alarm_arm
                && (s == 6'd59) && (m_n == alarm_m)
                && (h_n == alarm_h);
  end
`endif

  always_comb begin
    pm_o   = (h24 >= 5'd12);
    hour_o = h24;
    if (mode_12h) begin
      unique case (1'b1)
        (h24 == 5'd0):  hour_o = 5'd12;
        (h24 >  5'd12): hour_o = h24 - 5'd12;
        default:        hour_o = h24;
      endcase
    end
  end

  assign min_o = m;
  assign sec_o = s;

endmodule

// File: tb/tb_rtc_hms_timekeeper.sv
// Directed bench for rtc_hms_timekeeper at TICK_DIV=4.
// Alarm checks build only with RTC_ALARM_EN defined.
module tb_rtc_hms_timekeeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       mode_12h;
  logic [4:0] hour_o;
  logic       pm_o;
  logic [5:0] min_o;
  logic [5:0] sec_o;
  logic       sec_pulse;
  logic       day_pulse;
`ifdef RTC_ALARM_EN
  logic [4:0] alarm_h;
  logic [5:0] alarm_m;
  logic       alarm_arm;
  logic       alarm_hit;
`endif

  int checks   = 0;
  int failures = 0;
  logic r0, r1, r2, e1;

  rtc_hms_timekeeper_if sif ();

  rtc_hms_timekeeper #(
    .TICK_DIV (4),
    .DIV_W    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mode_12h  (mode_12h),
    .set       (sif),
`ifdef RTC_ALARM_EN
    .alarm_h   (alarm_h),
    .alarm_m   (alarm_m),
    .alarm_arm (alarm_arm),
    .alarm_hit (alarm_hit),
`endif
    .hour_o    (hour_o),
    .pm_o      (pm_o),
    .min_o     (min_o),
    .sec_o     (sec_o),
    .sec_pulse (sec_pulse),
    .day_pulse (day_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [4:0] h,
                        input logic       pm,
                        input logic [5:0] mm,
                        input logic [5:0] ss,
                        input logic       m12);
    sif.set_valid = 1'b1;
    sif.set_h     = h;
    sif.set_pm    = pm;
    sif.set_m     = mm;
    sif.set_s     = ss;
    mode_12h      = m12;
    step();
    sif.set_valid = 1'b0;
    r0 = sif.set_ready;
    step();
    e1 = sif.set_err;
    r1 = sif.set_ready;
    r2 = 1'b1;
    if (!e1) begin
      step();
      r2 = sif.set_ready;
    end
  endtask

  task automatic chk_hms(input string tag,
                         input int h,
                         input int mm,
                         input int ss);
    mode_12h = 1'b0;
    #1;
    chk({tag, "_h"}, 32'(hour_o), 32'(h));
    chk({tag, "_m"}, 32'(min_o), 32'(mm));
    chk({tag, "_s"}, 32'(sec_o), 32'(ss));
  endtask

  logic [4:0] bad_h  [4] = '{5'd0, 5'd24, 5'd1, 5'd1};
  logic [5:0] bad_m  [4] = '{6'd0, 6'd0, 6'd60, 6'd0};
  logic [5:0] bad_s  [4] = '{6'd0, 6'd0, 6'd0, 6'd60};
  logic       bad_12 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int np;
    rst           = 1'b1;
    run           = 1'b0;
    mode_12h      = 1'b1;
    sif.set_valid = 1'b0;
    sif.set_h     = '0;
    sif.set_pm    = 1'b0;
    sif.set_m     = '0;
    sif.set_s     = '0;
`ifdef RTC_ALARM_EN
    alarm_h   = 5'd0;
    alarm_m   = 6'd1;
    alarm_arm = 1'b0;
`endif
    step();
    step();
    chk("rst_h12", 32'(hour_o), 32'd12);
    chk("rst_pm", 32'(pm_o), 32'd0);
    chk("rst_ready", 32'(sif.set_ready), 32'd1);
    chk("rst_err", 32'(sif.set_err), 32'd0);
    chk("rst_secp", 32'(sec_pulse), 32'd0);
    chk("rst_dayp", 32'(day_pulse), 32'd0);
    chk_hms("rst", 0, 0, 0);

    rst      = 1'b0;
    mode_12h = 1'b1;
    run      = 1'b1;
    np       = 0;
    repeat (12) begin
      step();
      np += int'(sec_pulse);
    end
    chk("run_npulse", 32'(np), 32'd3);
    chk("run_sec", 32'(sec_o), 32'd3);
    chk("run_h12", 32'(hour_o), 32'd12);
    chk("run_pm", 32'(pm_o), 32'd0);
    mode_12h = 1'b0;
    #1;
    chk("run_h24", 32'(hour_o), 32'd0);

    run = 1'b0;
    do_set(5'd23, 1'b0, 6'd59, 6'd58, 1'b0);
    chk("set1_r0", 32'(r0), 32'd0);
    chk("set1_r1", 32'(r1), 32'd0);
    chk("set1_r2", 32'(r2), 32'd1);
    chk("set1_err", 32'(e1), 32'd0);
    chk_hms("set1", 23, 59, 58);
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) begin
        chk("roll_sp4", 32'(sec_pulse), 32'd1);
        chk("roll_dp4", 32'(day_pulse), 32'd0);
      end
      if (i == 8) begin
        chk("roll_sp8", 32'(sec_pulse), 32'd1);
        chk("roll_dp8", 32'(day_pulse), 32'd1);
      end
    end
    run = 1'b0;
    chk_hms("roll", 0, 0, 0);
    mode_12h = 1'b1;
    #1;
    chk("roll_h12", 32'(hour_o), 32'd12);
    chk("roll_pm", 32'(pm_o), 32'd0);

    do_set(5'd12, 1'b0, 6'd7, 6'd30, 1'b1);
    chk_hms("12am", 0, 7, 30);
    do_set(5'd12, 1'b1, 6'd7, 6'd30, 1'b1);
    chk_hms("12pm", 12, 7, 30);
    mode_12h = 1'b1;
    #1;
    chk("12pm_h12", 32'(hour_o), 32'd12);
    chk("12pm_pm", 32'(pm_o), 32'd1);
    do_set(5'd11, 1'b1, 6'd7, 6'd30, 1'b1);
    chk_hms("11pm", 23, 7, 30);

    for (int k = 0; k < 4; k++) begin
      do_set(bad_h[k], 1'b0, bad_m[k],
             bad_s[k], bad_12[k]);
      chk($sformatf("bad%0d_err", k), 32'(e1), 32'd1);
      chk($sformatf("bad%0d_r0", k), 32'(r0), 32'd0);
      chk($sformatf("bad%0d_r1", k), 32'(r1), 32'd1);
      step();
      chk($sformatf("bad%0d_errlo", k),
          32'(sif.set_err), 32'd0);
      chk_hms($sformatf("bad%0d", k), 23, 7, 30);
    end

    run = 1'b1;
    step();
    do_set(5'd10, 1'b0, 6'd20, 6'd30, 1'b0);
    chk("wrap_err", 32'(e1), 32'd0);
    chk("wrap_secp", 32'(sec_pulse), 32'd0);
    chk_hms("wrap", 10, 20, 30);
    np = 0;
    repeat (3) begin
      step();
      np += int'(sec_pulse);
    end
    chk("wrap_early", 32'(np), 32'd0);
    step();
    chk("wrap_sp4", 32'(sec_pulse), 32'd1);
    chk("wrap_sec", 32'(sec_o), 32'd31);
    run = 1'b0;

    sif.set_valid = 1'b1;
    sif.set_h     = 5'd5;
    sif.set_m     = 6'd6;
    sif.set_s     = 6'd7;
    mode_12h      = 1'b0;
    step();
    sif.set_valid = 1'b0;
    chk("abort_busy", 32'(sif.set_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_hms("abort", 0, 0, 0);
    chk("abort_ready", 32'(sif.set_ready), 32'd1);
    chk("abort_err", 32'(sif.set_err), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("abort_err2", 32'(sif.set_err), 32'd0);
    chk("abort_ready2", 32'(sif.set_ready), 32'd1);
    chk_hms("abort2", 0, 0, 0);

`ifdef RTC_ALARM_EN
    alarm_h   = 5'd0;
    alarm_m   = 6'd1;
    alarm_arm = 1'b1;
    do_set(5'd0, 1'b0, 6'd0, 6'd58, 1'b0);
    run = 1'b1;
    np  = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      np += int'(alarm_hit);
      if (i == 8)
        chk("alarm_hit8", 32'(alarm_hit), 32'd1);
    end
    chk("alarm_count", 32'(np), 32'd1);
    run       = 1'b0;
    alarm_arm = 1'b0;
    do_set(5'd0, 1'b0, 6'd0, 6'd58, 1'b0);
    run = 1'b1;
    np  = 0;
    repeat (8) begin
      step();
      np += int'(alarm_hit);
    end
    chk("alarm_off", 32'(np), 32'd0);
    chk_hms("alarm_off", 0, 1, 0);
    run = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
